commutation_scheduler: RTL and testbench

//   Sequences DesiredLoad updates from the MCU into the three per-phase commutation FSMs.

---
 rtl/commutation_scheduler.sv | 154 +++++++++++++++
 tb/tb_commutation_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/commutation_scheduler.sv
// rtl/commutation_scheduler.sv - sequences DesiredLoad updates A->B->C into the phase FSMs with settle gaps
module commutation_scheduler #(
  parameter int SETTLE_CYCLES = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       short,
  input  logic       cmd_valid,
  input  logic [5:0] cmd_load,
  output logic       cmd_ready,
  output logic       cmd_err,
  output logic [5:0] phase_load,
  output logic       fsm_rst,
  output logic       busy,
  output logic       fault,
  output logic [1:0] seq_phase
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_READY  = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        r_state;
  logic [5:0]    r_pending;
  logic [5:0]    r_phase_load;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_err;
  logic          r_fsm_rst;
  logic          r_busy;
  logic          r_fault;
  logic [1:0]    r_seq_phase;

  logic          w_accept;
  logic          w_illegal;
  logic [2:0]    w_first;
  logic [2:0]    w_next;

  // Lowest-order phase at or above 'from' whose field differs; bit 2 flags a hit.
  function automatic logic [2:0] find_diff(input logic [5:0] a, input logic [5:0] b,
                                           input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if ((3'(i) >= from) && (a[2*(2-i) +: 2] != b[2*(2-i) +: 2])) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  // Commands are taken only while idle and running, never on a short-circuit cycle.
  assign cmd_ready = (r_state == S_READY) & start & ~short;
  assign w_accept  = cmd_ready & cmd_valid;
  assign w_illegal = (cmd_load[5:4] == 2'b11) | (cmd_load[3:2] == 2'b11) |
                     (cmd_load[1:0] == 2'b11);
  assign w_first   = find_diff(cmd_load, r_phase_load, 3'd0);
  assign w_next    = find_diff(r_pending, r_phase_load, {1'b0, r_idx} + 3'd1);

  assign cmd_err    = r_cmd_err;
  assign phase_load = r_phase_load;
  assign fsm_rst    = r_fsm_rst;
  assign busy       = r_busy;
  assign fault      = r_fault;
  assign seq_phase  = r_seq_phase;

  // Scheduler FSM: short beats start, start beats normal sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_pending    <= 6'd0;
      r_phase_load <= 6'd0;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_cmd_err    <= 1'b0;
      r_fsm_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_fault      <= 1'b0;
      r_seq_phase  <= 2'd0;
    end else begin
      r_cmd_err <= 1'b0;
      if (r_state == S_FAULT) begin
        r_state <= S_FAULT;
      end else if (short) begin
        r_state      <= S_FAULT;
        r_phase_load <= 6'd0;
        r_fsm_rst    <= 1'b1;
        r_fault      <= 1'b1;
        r_busy       <= 1'b0;
        r_seq_phase  <= 2'd0;
      end else if (r_state == S_OFF) begin
        if (start) begin
          r_state   <= S_READY;
          r_fsm_rst <= 1'b0;
        end
      end else if (!start) begin
        r_state      <= S_OFF;
        r_phase_load <= 6'd0;
        r_fsm_rst    <= 1'b1;
        r_busy       <= 1'b0;
        r_seq_phase  <= 2'd0;
      end else begin
        case (r_state)
          S_READY: begin
            if (w_accept) begin
              r_pending <= cmd_load;
              if (w_illegal) begin
                r_cmd_err <= 1'b1;
              end else if (w_first[2]) begin
                r_state     <= S_APPLY;
                r_idx       <= w_first[1:0];
                r_busy      <= 1'b1;
                r_seq_phase <= w_first[1:0];
              end
            end
          end
          S_APPLY: begin
            case (r_idx)
              2'd0:    r_phase_load[5:4] <= r_pending[5:4];
              2'd1:    r_phase_load[3:2] <= r_pending[3:2];
              default: r_phase_load[1:0] <= r_pending[1:0];
            endcase
            r_cnt   <= CW'(SETTLE_CYCLES - 1);
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == '0) begin
              if (w_next[2]) begin
                r_state     <= S_APPLY;
                r_idx       <= w_next[1:0];
                r_seq_phase <= w_next[1:0];
              end else begin
                r_state     <= S_READY;
                r_busy      <= 1'b0;
                r_seq_phase <= 2'd0;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_commutation_scheduler.sv
// tb/tb_commutation_scheduler.sv - randomized and directed checks of commutation_scheduler against a timing model
module tb_commutation_scheduler;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       short = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [5:0] cmd_load = 6'd0;
  logic       cmd_ready;
  logic       cmd_err;
  logic [5:0] phase_load;
  logic       fsm_rst;
  logic       busy;
  logic       fault;
  logic [1:0] seq_phase;

  int n_checks = 0;
  int n_errors = 0;

  commutation_scheduler #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .short(short),
    .cmd_valid(cmd_valid), .cmd_load(cmd_load), .cmd_ready(cmd_ready),
    .cmd_err(cmd_err), .phase_load(phase_load), .fsm_rst(fsm_rst),
    .busy(busy), .fault(fault), .seq_phase(seq_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fld(input logic [5:0] v, input int p);
    return v[(5 - 2*p) -: 2];
  endfunction

  // Model: 0=off, 1=ready, 2=sequencing, 3=fault. A sequence is a list of
  // differing phases; phase j of the list lands 1+j*(S+1) edges after accept.
  int         m_mode;
  logic [1:0] m_load [3];
  logic [5:0] m_tgt;
  int         m_diff [$];
  int         m_t;
  logic       m_rst, m_err, m_busy, m_fault;
  int         m_seq;

  function automatic logic [5:0] m_pl();
    return {m_load[0], m_load[1], m_load[2]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_load[0] = 0; m_load[1] = 0; m_load[2] = 0;
      m_rst = 1; m_err = 0; m_busy = 0; m_fault = 0; m_seq = 0;
      m_diff.delete();
    end else begin
      m_err = 0;
      if (m_mode == 3) begin
        m_mode = 3;
      end else if (short) begin
        m_mode = 3; m_load[0] = 0; m_load[1] = 0; m_load[2] = 0;
        m_rst = 1; m_fault = 1; m_busy = 0; m_seq = 0;
      end else if (m_mode == 0) begin
        if (start) begin m_mode = 1; m_rst = 0; end
      end else if (!start) begin
        m_mode = 0; m_load[0] = 0; m_load[1] = 0; m_load[2] = 0;
        m_rst = 1; m_busy = 0; m_seq = 0;
      end else if (m_mode == 1) begin
        if (cmd_valid) begin
          if (fld(cmd_load, 0) == 3 || fld(cmd_load, 1) == 3 || fld(cmd_load, 2) == 3) begin
            m_err = 1;
          end else begin
            m_diff.delete();
            for (int p = 0; p < 3; p++) if (fld(cmd_load, p) != m_load[p]) m_diff.push_back(p);
            if (m_diff.size() > 0) begin
              m_mode = 2; m_tgt = cmd_load; m_t = 0; m_busy = 1; m_seq = m_diff[0];
            end
          end
        end
      end else begin
        m_t++;
        for (int j = 0; j < m_diff.size(); j++)
          if (m_t == 1 + j*(S+1)) m_load[m_diff[j]] = fld(m_tgt, m_diff[j]);
        if (m_t == 1 + (m_diff.size()-1)*(S+1) + S) begin
          m_mode = 1; m_busy = 0; m_seq = 0;
        end else begin
          for (int j = 0; j < m_diff.size(); j++) if (m_t >= j*(S+1)) m_seq = m_diff[j];
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    chk("phase_load", 32'(phase_load), 32'(m_pl()));
    chk("fsm_rst", 32'(fsm_rst), 32'(m_rst));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("seq_phase", 32'(seq_phase), 32'(m_seq));
    chk("cmd_ready", 32'(cmd_ready), 32'((m_mode == 1) && start && !short));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic accept(input logic [5:0] v);
    cmd_valid = 1'b1; cmd_load = v; tick(); cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state and power-up
    tick(2);
    chk("rst_phase_load", 32'(phase_load), 32'h0);
    chk("rst_fsm_rst", 32'(fsm_rst), 32'h1);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    rst_n = 1'b1; start = 1'b1;
    tick();
    chk("up_fsm_rst", 32'(fsm_rst), 32'h0);
    chk("up_ready", 32'(cmd_ready), 32'h1);

    // Full A/B/C sequence
    accept(6'b011001);
    chk("seq_busy_k", 32'(busy), 32'h1);
    chk("seq_pl_k", 32'(phase_load), 32'h00);
    tick();  chk("seq_pl_k1", 32'(phase_load), 32'b010000);
    tick(4); chk("seq_ph_k5", 32'(seq_phase), 32'h1);
    chk("seq_pl_k5", 32'(phase_load), 32'b010000);
    tick();  chk("seq_pl_k6", 32'(phase_load), 32'b011000);
    tick(5); chk("seq_pl_k11", 32'(phase_load), 32'b011001);
    chk("seq_ph_k11", 32'(seq_phase), 32'h2);
    tick(3); chk("seq_ready_k14", 32'(cmd_ready), 32'h0);
    tick();  chk("seq_ready_k15", 32'(cmd_ready), 32'h1);
    chk("seq_busy_k15", 32'(busy), 32'h0);

    // Only C differs
    accept(6'b011010);
    tick();  chk("c_pl_k1", 32'(phase_load), 32'b011010);
    tick(3); chk("c_busy_k4", 32'(busy), 32'h1);
    tick();  chk("c_busy_k5", 32'(busy), 32'h0);

    // Illegal field
    accept(6'b110000);
    chk("err_pulse", 32'(cmd_err), 32'h1);
    chk("err_ready", 32'(cmd_ready), 32'h1);
    tick();  chk("err_clear", 32'(cmd_err), 32'h0);
    chk("err_pl", 32'(phase_load), 32'b011010);

    // start dropped mid-settle of phase B
    accept(6'b100101);
    tick(8);
    start = 1'b0;
    tick();
    chk("off_pl", 32'(phase_load), 32'h0);
    chk("off_rst", 32'(fsm_rst), 32'h1);
    chk("off_busy", 32'(busy), 32'h0);

    // Sticky short fault
    start = 1'b1; tick();
    short = 1'b1; tick(); short = 1'b0;
    chk("flt_fault", 32'(fault), 32'h1);
    chk("flt_rst", 32'(fsm_rst), 32'h1);
    for (int i = 0; i < 6; i++) begin
      start = i[0]; cmd_valid = 1'b1; cmd_load = 6'b010101; tick();
    end
    cmd_valid = 1'b0; start = 1'b1;
    chk("flt_hold", 32'(fault), 32'h1);
    chk("flt_pl", 32'(phase_load), 32'h0);
    rst_n = 1'b0; #1;
    chk("flt_async_clear", 32'(fault), 32'h0);
    tick(); rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      short = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 99) != 0);
      cmd_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 7);
      if (r == 0) cmd_load = 6'($urandom);
      else if (r == 1) cmd_load = m_pl();
      else cmd_load = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      if (m_mode == 3 && $urandom_range(0, 19) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
